// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS sweep sequencer.
// Register map, FSM state encoding and default widths.
package dds_pkg;

    localparam int ADDR_W_D  = 14;
    localparam int PHASE_W_D = 32;
    localparam int CNT_W_D   = 16;
    localparam int ROM_LAT_D = 1;

    localparam logic [2:0] REG_FTW_START = 3'd0;
    localparam logic [2:0] REG_FTW_STEP  = 3'd1;
    localparam logic [2:0] REG_N_STEPS   = 3'd2;
    localparam logic [2:0] REG_DWELL     = 3'd3;
    localparam logic [2:0] REG_OFS_B     = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator with tuning-word step adder.
// Channel B address is channel A plus a fixed offset, wrapping.
module dds_phase_acc
    import dds_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_D,
    parameter int PHASE_W = PHASE_W_D
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_run,
    input  logic               i_step_en,
    input  logic [PHASE_W-1:0] i_ftw_start,
    input  logic [PHASE_W-1:0] i_ftw_step,
    input  logic [ADDR_W-1:0]  i_ofs_b,
    output logic [ADDR_W-1:0]  o_addr_a,
    output logic [ADDR_W-1:0]  o_addr_b
);

    logic [PHASE_W-1:0] r_acc;
    logic [PHASE_W-1:0] r_ftw;
    logic [ADDR_W-1:0]  w_addr_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_ftw <= '0;
        end else if (i_load) begin
            r_acc <= '0;
            r_ftw <= i_ftw_start;
        end else if (i_run) begin
            r_acc <= r_acc + r_ftw;
            if (i_step_en) begin
                r_ftw <= r_ftw + i_ftw_step;
            end
        end
    end

    // Accumulator only moves in RUN, so addresses hold while idle.
    assign w_addr_a = r_acc[PHASE_W-1 -: ADDR_W];
    assign o_addr_a = w_addr_a;
    assign o_addr_b = w_addr_a + i_ofs_b;

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS sweep sequencer: config/shadow registers, run FSM, dwell and
// step counters, and ROM-latency aligned sample valid.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_D,
    parameter int PHASE_W = PHASE_W_D,
    parameter int CNT_W   = CNT_W_D,
    parameter int ROM_LAT = ROM_LAT_D
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_addr,
    input  logic [PHASE_W-1:0] cfg_wdata,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  addr_a,
    output logic [ADDR_W-1:0]  addr_b,
    output logic               addr_valid,
    output logic               samp_valid
);

    state_t r_state;
    state_t w_state_nx;

    logic [PHASE_W-1:0] r_cfg_ftw_start;
    logic [PHASE_W-1:0] r_cfg_ftw_step;
    logic [CNT_W-1:0]   r_cfg_n_steps;
    logic [CNT_W-1:0]   r_cfg_dwell;
    logic [ADDR_W-1:0]  r_cfg_ofs_b;

    logic [PHASE_W-1:0] r_sh_ftw_step;
    logic [CNT_W-1:0]   r_sh_n_steps;
    logic [CNT_W-1:0]   r_sh_dwell;
    logic [ADDR_W-1:0]  r_sh_ofs_b;

    logic [CNT_W-1:0]   r_dwell_cnt;
    logic [CNT_W-1:0]   r_step_cnt;
    logic [ROM_LAT-1:0] r_sv;

    logic               w_accept;
    logic               w_run;
    logic [CNT_W-1:0]   w_dwell_eff;
    logic               w_dwell_last;
    logic               w_sweep;
    logic               w_term;
    logic               w_step_en;

    assign w_accept     = (r_state == IDLE) && start && !stop;
    assign w_run        = (r_state == RUN);
    assign w_dwell_eff  = (r_sh_dwell == '0) ? CNT_W'(1) : r_sh_dwell;
    assign w_dwell_last = (r_dwell_cnt == w_dwell_eff - CNT_W'(1));
    assign w_sweep      = (r_sh_n_steps != '0);
    assign w_term       = w_dwell_last && w_sweep &&
                          (r_step_cnt == r_sh_n_steps - CNT_W'(1));
    assign w_step_en    = w_run && w_dwell_last && w_sweep && !w_term;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_ftw_start <= '0;
            r_cfg_ftw_step  <= '0;
            r_cfg_n_steps   <= '0;
            r_cfg_dwell     <= '0;
            r_cfg_ofs_b     <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                REG_FTW_START: r_cfg_ftw_start <= cfg_wdata;
                REG_FTW_STEP:  r_cfg_ftw_step  <= cfg_wdata;
                REG_N_STEPS:   r_cfg_n_steps   <= cfg_wdata[CNT_W-1:0];
                REG_DWELL:     r_cfg_dwell     <= cfg_wdata[CNT_W-1:0];
                REG_OFS_B:     r_cfg_ofs_b     <= cfg_wdata[ADDR_W-1:0];
                default: ;
            endcase
        end
    end

    // Shadows sample the pre-write config when start and cfg_we coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_ftw_step <= '0;
            r_sh_n_steps  <= '0;
            r_sh_dwell    <= '0;
            r_sh_ofs_b    <= '0;
        end else if (w_accept) begin
            r_sh_ftw_step <= r_cfg_ftw_step;
            r_sh_n_steps  <= r_cfg_n_steps;
            r_sh_dwell    <= r_cfg_dwell;
            r_sh_ofs_b    <= r_cfg_ofs_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE: begin
                if (start && !stop) w_state_nx = RUN;
            end
            RUN: begin
                if (stop)        w_state_nx = IDLE;
                else if (w_term) w_state_nx = DONE;
            end
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dwell_cnt <= '0;
            r_step_cnt  <= '0;
        end else if (w_accept) begin
            r_dwell_cnt <= '0;
            r_step_cnt  <= '0;
        end else if (w_run) begin
            r_dwell_cnt <= w_dwell_last ? '0 : r_dwell_cnt + CNT_W'(1);
            if (w_step_en) begin
                r_step_cnt <= r_step_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sv <= '0;
        end else begin
            r_sv[0] <= w_run;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_sv[i] <= r_sv[i-1];
            end
        end
    end

    dds_phase_acc #(
        .ADDR_W  (ADDR_W),
        .PHASE_W (PHASE_W)
    ) u_phase_acc (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept),
        .i_run       (w_run),
        .i_step_en   (w_step_en),
        .i_ftw_start (r_cfg_ftw_start),
        .i_ftw_step  (r_sh_ftw_step),
        .i_ofs_b     (r_sh_ofs_b),
        .o_addr_a    (addr_a),
        .o_addr_b    (addr_b)
    );

    assign busy       = w_run;
    assign done       = (r_state == DONE);
    assign addr_valid = w_run;
    assign samp_valid = r_sv[ROM_LAT-1];

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: closed-form sweep model compared every
// cycle, directed scenarios with literal addresses, then random traffic.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        start;
    logic        stop;
    logic        busy;
    logic        done;
    logic [13:0] addr_a;
    logic [13:0] addr_b;
    logic        addr_valid;
    logic        samp_valid;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    dds_sweep_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .done       (done),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .addr_valid (addr_valid),
        .samp_valid (samp_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    // Model: the run is a sequence of cycles k = 0,1,..; the tuning word
    // used at cycle k is start + step * (k / dwell), and the run length
    // is n_steps * dwell cycles unless n_steps is 0 (free-run).
    logic [31:0] m_cfg [5];
    logic [31:0] sh_fs;
    logic [31:0] sh_step;
    int          sh_n;
    int          sh_d;
    logic [13:0] sh_ofs;
    bit          m_run;
    bit          m_done;
    bit          m_sv;
    bit          was_done;
    int          m_k;
    logic [31:0] m_acc;

    function automatic logic [31:0] ftw_at(input int j);
        if (sh_n == 0) return sh_fs;
        return sh_fs + sh_step * 32'(j / sh_d);
    endfunction

    function automatic logic [13:0] exp_a();
        return m_acc[31:18];
    endfunction

    function automatic logic [13:0] exp_b();
        logic [13:0] a;
        a = m_acc[31:18];
        return a + sh_ofs;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) m_cfg[i] = '0;
            sh_fs = '0; sh_step = '0; sh_n = 0; sh_d = 1; sh_ofs = '0;
            m_run = 0; m_done = 0; m_sv = 0; m_k = 0; m_acc = '0;
        end else begin
            was_done = m_done;
            m_done   = 0;
            m_sv     = m_run;
            if (m_run) begin
                if (stop) begin
                    m_run = 0;
                end else begin
                    m_acc = m_acc + ftw_at(m_k);
                    m_k++;
                    if (sh_n != 0 && m_k == sh_n * sh_d) begin
                        m_run  = 0;
                        m_done = 1;
                    end
                end
            end else if (!was_done && start && !stop) begin
                sh_fs   = m_cfg[0];
                sh_step = m_cfg[1];
                sh_n    = int'(m_cfg[2][15:0]);
                sh_d    = (m_cfg[3][15:0] == 16'd0) ? 1 : int'(m_cfg[3][15:0]);
                sh_ofs  = m_cfg[4][13:0];
                m_run   = 1;
                m_k     = 0;
                m_acc   = '0;
            end
            if (cfg_we && cfg_addr < 3'd5) begin
                case (cfg_addr)
                    3'd2, 3'd3: m_cfg[cfg_addr] = {16'h0, cfg_wdata[15:0]};
                    3'd4:       m_cfg[cfg_addr] = {18'h0, cfg_wdata[13:0]};
                    default:    m_cfg[cfg_addr] = cfg_wdata;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_run));
            chk("done", 32'(done), 32'(m_done));
            chk("addr_valid", 32'(addr_valid), 32'(m_run));
            chk("samp_valid", 32'(samp_valid), 32'(m_sv));
            if (m_run) begin
                chk("addr_a", 32'(addr_a), 32'(exp_a()));
                chk("addr_b", 32'(addr_b), 32'(exp_b()));
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic go();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic halt();
        @(negedge clk);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    logic [13:0] t2 [6];

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        start = 1'b0; stop = 1'b0;
        t2 = '{14'd0, 14'd1, 14'd2, 14'd4, 14'd6, 14'd9};
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_addr_a", 32'(addr_a), 32'h0);
        chk("rst_addr_b", 32'(addr_b), 32'h0);
        chk("rst_samp", 32'(samp_valid), 32'h0);

        // 1: legacy +16 rate
        wr(3'd0, 32'h0040_0000);
        wr(3'd4, 32'h0000_1000);
        go();
        @(negedge clk);
        chk("t1_a0", 32'(addr_a), 32'h0);
        chk("t1_b0", 32'(addr_b), 32'h1000);
        chk("t1_sv0", 32'(samp_valid), 32'h0);
        @(negedge clk);
        chk("t1_a1", 32'(addr_a), 32'd16);
        chk("t1_b1", 32'(addr_b), 32'h1010);
        chk("t1_sv1", 32'(samp_valid), 32'h1);
        @(negedge clk);
        chk("t1_a2", 32'(addr_a), 32'd32);
        repeat (10) @(negedge clk);
        chk("t1_busy", 32'(busy), 32'h1);
        halt();

        // 2: stepped sweep
        wr(3'd0, 32'h0004_0000);
        wr(3'd1, 32'h0004_0000);
        wr(3'd2, 32'd3);
        wr(3'd3, 32'd2);
        go();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t2_valid", 32'(addr_valid), 32'h1);
            chk("t2_addr", 32'(addr_a), 32'(t2[i]));
        end
        @(negedge clk);
        chk("t2_done", 32'(done), 32'h1);
        chk("t2_valid_end", 32'(addr_valid), 32'h0);
        @(negedge clk);
        chk("t2_done_off", 32'(done), 32'h0);
        chk("t2_idle", 32'(busy), 32'h0);

        // 3: stop mid-run, then restart
        wr(3'd2, 32'd0);
        go();
        repeat (4) @(posedge clk);
        halt();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_busy", 32'(busy), 32'h0);
            chk("t3_done", 32'(done), 32'h0);
        end
        go();
        @(negedge clk);
        chk("t3_restart", 32'(addr_a), 32'h0);
        halt();

        // 4: reset in third run cycle
        go();
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t4_busy", 32'(busy), 32'h0);
        chk("t4_done", 32'(done), 32'h0);
        chk("t4_a", 32'(addr_a), 32'h0);
        chk("t4_b", 32'(addr_b), 32'h0);
        chk("t4_sv", 32'(samp_valid), 32'h0);
        go();
        repeat (3) @(negedge clk);
        chk("t4_cfg_a", 32'(addr_a), 32'h0);
        chk("t4_cfg_b", 32'(addr_b), 32'h0);
        halt();

        // 5: wrap, shadowing, start+stop
        wr(3'd0, 32'h0040_0000);
        wr(3'd4, 32'h0000_3FF0);
        go();
        @(negedge clk);
        chk("t5_b0", 32'(addr_b), 32'h3FF0);
        @(negedge clk);
        chk("t5_b1", 32'(addr_b), 32'h0000);
        @(negedge clk);
        chk("t5_a2", 32'(addr_a), 32'h0020);
        chk("t5_b2", 32'(addr_b), 32'h0010);
        wr(3'd0, 32'h0080_0000);
        @(negedge clk);
        chk("t5_shadow", 32'(addr_a), 32'h0040);
        halt();
        @(negedge clk);
        start = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 32'h0040_0000;
        @(posedge clk); #1;
        start = 1'b0; cfg_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_prewrite", 32'(addr_a), 32'h0020);
        halt();
        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_startstop", 32'(busy), 32'h0);
        end

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 299) == 0);
            start    = ($urandom_range(0, 5) == 0);
            stop     = ($urandom_range(0, 39) == 0);
            cfg_we   = ($urandom_range(0, 3) == 0);
            cfg_addr = 3'($urandom_range(0, 7));
            case (cfg_addr)
                3'd2:    cfg_wdata = {$urandom_range(0, 1) ? 16'hFFFF : 16'h0,
                                      16'($urandom_range(0, 4))};
                3'd3:    cfg_wdata = 32'($urandom_range(0, 3));
                default: cfg_wdata = $urandom;
            endcase
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
        repeat (20) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
